colour_seq_lock: RTL



---
 rtl/colour_seq_lock_pkg.sv | 23 ++
 rtl/colour_seq_lock_onehot_idx.sv | 21 ++
 rtl/colour_seq_lock.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/colour_seq_lock_pkg.sv
// Shared definitions for the colour-sequence lock: FSM state encoding,
// a width helper that never returns zero, and the default colour indices.
package colour_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    MATCH = 2'd2,
    LOCK  = 2'd3
  } state_t;

  localparam int RED   = 0;
  localparam int GREEN = 1;
  localparam int BLUE  = 2;

  // $clog2 clamped to at least one bit so degenerate counts still get a wire
  function automatic int safe_clog2(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/colour_seq_lock_onehot_idx.sv
// One-hot colour vector to binary index. valid is high only when exactly one
// button is pressed; idx is meaningless otherwise.
module onehot_idx #(
  parameter int NCOL = 3,
  parameter int CW   = 2
) (
  input  logic [NCOL-1:0] col,
  output logic [CW-1:0]   idx,
  output logic            valid
);

  // OR together the indices of all set bits; exact for a one-hot input
  always_comb begin
    idx = '0;
    for (int i = 0; i < NCOL; i++) begin
      if (col[i]) idx = idx | CW'(i);
    end
    valid = $onehot(col);
  end

endmodule

// File: rtl/colour_seq_lock.sv
// Runtime-programmable colour-sequence lock with wrong-attempt lockout.
// A start request captures the pattern, then LEN advance strobes must each
// present the expected colour one-hot. MAX_ERR consecutive failures lock the
// unit out for LOCK_CYC cycles. Outputs are pure functions of the state.
// Optional: define COLOUR_SEQ_TIMEOUT_EN to fail an attempt after
// TIMEOUT_CYC quiet cycles without an advance strobe.
module colour_seq_lock
  import colour_seq_pkg::*;
#(
  parameter int NCOL        = 3,
  parameter int LEN         = 4,
  parameter int MAX_ERR     = 3,
  parameter int LOCK_CYC    = 16,
  parameter int TIMEOUT_CYC = 64,
  localparam int CW         = safe_clog2(NCOL),
  localparam int IW         = $clog2(LEN + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s,
  input  logic [NCOL-1:0]     col,
  input  logic                a,
  input  logic [LEN*CW-1:0]   pat,
  output logic                u,
  output logic                busy,
  output logic                locked,
  output logic [IW-1:0]       idx
);

  localparam int EW = $clog2(MAX_ERR + 1);
  localparam int LW = safe_clog2(LOCK_CYC);

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [EW-1:0]       err_q, err_d;
  logic [LW-1:0]       lock_q, lock_d;
  logic [LEN*CW-1:0]   pat_q, pat_d;

`ifdef COLOUR_SEQ_TIMEOUT_EN
  localparam int TW = safe_clog2(TIMEOUT_CYC);
  logic [TW-1:0]       tmo_q, tmo_d;
`endif

  logic [CW-1:0]       col_idx;
  logic                col_vld;
  logic [CW-1:0]       exp_sym;
  logic                press_ok;
  logic                fail;

  onehot_idx #(
    .NCOL (NCOL),
    .CW   (CW)
  ) u_col_dec (
    .col   (col),
    .idx   (col_idx),
    .valid (col_vld)
  );

  // Select the captured symbol the next press must match
  always_comb begin
    exp_sym = '0;
    for (int i = 0; i < LEN; i++) begin
      if (idx_q == IW'(i)) exp_sym = pat_q[i*CW +: CW];
    end
    press_ok = col_vld && (col_idx == exp_sym);
  end

  // Next-state logic: attempt progress, failure accounting and lockout timing
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    lock_d  = lock_q;
    pat_d   = pat_q;
    fail    = 1'b0;
`ifdef COLOUR_SEQ_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (s) begin
          state_d = ARMED;
          idx_d   = '0;
          pat_d   = pat;
`ifdef COLOUR_SEQ_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      ARMED: begin
        if (a) begin
          if (press_ok) begin
`ifdef COLOUR_SEQ_TIMEOUT_EN
            tmo_d = '0;
`endif
            if (idx_q == IW'(LEN - 1)) begin
              state_d = MATCH;
              idx_d   = IW'(LEN);
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            fail = 1'b1;
          end
        end
`ifdef COLOUR_SEQ_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          fail = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
        // A failure restarts the attempt; the last allowed one trips lockout
        if (fail) begin
          idx_d = '0;
          if (err_q + EW'(1) == EW'(MAX_ERR)) begin
            state_d = LOCK;
            lock_d  = LW'(LOCK_CYC - 1);
            err_d   = '0;
          end else begin
            state_d = IDLE;
            err_d   = err_q + EW'(1);
          end
        end
      end
      MATCH: begin
        state_d = IDLE;
        err_d   = '0;
        idx_d   = '0;
      end
      LOCK: begin
        if (lock_q == '0) begin
          state_d = IDLE;
        end else begin
          lock_d = lock_q - LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers; reset overrides every other input
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      lock_q  <= '0;
      pat_q   <= '0;
`ifdef COLOUR_SEQ_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      lock_q  <= lock_d;
      pat_q   <= pat_d;
`ifdef COLOUR_SEQ_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign u      = (state_q == MATCH);
  assign busy   = (state_q == ARMED);
  assign locked = (state_q == LOCK);
  assign idx    = idx_q;

endmodule
